// File: rtl/vga_flash_responder_if.sv
// VGA frame-load read port: request level + byte address in, word + valid strobe out.
// Pure signal bundle, no logic; the VGA controller side is the master.
// Flow control is the held vga_re level answered by timed vga_success pulses.
interface vga_flash_responder_if;
  logic        vga_re;
  logic [22:0] vga_addr;
  logic [15:0] vga_data;
  logic        vga_success;

  modport master (
    output vga_re,
    output vga_addr,
    input  vga_data,
    input  vga_success
  );

  modport slave (
    input  vga_re,
    input  vga_addr,
    output vga_data,
    output vga_success
  );
endinterface

// File: rtl/vga_flash_responder.sv
// Read-only x16 NOR flash responder for the VGA frame loader; optional prefetch via VGA_FLASH_PREFETCH_EN.
// Latency: READ_CYCLES edges from request sample to vga_success (1 edge on a prefetch hit).
// Backpressure: none; vga_re low aborts a read, shortens an ack and drops any prefetch.
module vga_flash_responder #(
  parameter int READ_CYCLES = 5,
  parameter int ACK_CYCLES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_flash_responder_if.slave        vga,
  output logic [22:0]                 flash_a,
  inout  wire  [15:0]                 flash_d,
  output logic                        flash_ce_n,
  output logic                        flash_oe_n,
  output logic                        flash_we_n,
  output logic                        flash_rp_n,
  output logic                        flash_byte_n,
  output logic                        flash_vpen
);

  localparam logic [3:0] RD_LAST  = 4'(READ_CYCLES - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [22:0] flash_a_q, flash_a_d;
  logic        en_n_q, en_n_d;      // shared chip/output enable, active-low
  logic        success_q, success_d;

`ifdef VGA_FLASH_PREFETCH_EN
  logic [22:0] pf_addr_q, pf_addr_d;
  logic [15:0] pf_data_q, pf_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic        pf_busy_q, pf_busy_d;
  logic [3:0]  pf_cnt_q, pf_cnt_d;
  logic        pf_done;
  logic        pf_hit;
  logic        pf_start;
  logic [22:0] pf_base;
`endif

  // This block only ever reads the flash, so the data bus stays released.
  assign flash_d = 16'hzzzz;

  assign flash_a      = flash_a_q;
  assign flash_ce_n   = en_n_q;
  assign flash_oe_n   = en_n_q;
  assign flash_we_n   = 1'b1;
  assign flash_rp_n   = 1'b1;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b0;

  assign vga.vga_data    = data_q;
  assign vga.vga_success = success_q;

  // Word address bit 0 is meaningless on an x16 part; addr_q only feeds the prefetch path.
  logic unused_addr;
  assign unused_addr = ^{addr_q, vga.vga_addr[0]};

  // Next-state, counters, flash control and (optionally) prefetch engine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    flash_a_d = flash_a_q;
    en_n_d    = en_n_q;
    success_d = success_q;
`ifdef VGA_FLASH_PREFETCH_EN
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
    pf_busy_d  = pf_busy_q;
    pf_cnt_d   = pf_cnt_q;
    pf_start   = 1'b0;
    pf_base    = addr_q;
    pf_done    = pf_busy_q && (pf_cnt_q == RD_LAST);
    pf_hit     = vga.vga_re && (vga.vga_addr[22:1] == pf_addr_q[22:1])
                 && (pf_valid_q || pf_busy_q);

    // Background prefetch read runs through ACK/GAP/IDLE on its own counter.
    if (pf_busy_q) begin
      if (pf_done) begin
        pf_data_d  = flash_d;
        pf_valid_d = 1'b1;
        pf_busy_d  = 1'b0;
        en_n_d     = 1'b1;
      end else begin
        pf_cnt_d = pf_cnt_q + 4'd1;
      end
    end
`endif

    case (state_q)
      ST_IDLE: begin
        success_d = 1'b0;
        if (vga.vga_re) begin
          addr_d = vga.vga_addr;
`ifdef VGA_FLASH_PREFETCH_EN
          if (pf_hit && (pf_valid_q || pf_done)) begin
            // Buffered word (or one landing this very edge) goes straight out.
            data_d    = pf_valid_q ? pf_data_q : flash_d;
            success_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_ACK;
            pf_start  = 1'b1;
            pf_base   = vga.vga_addr;
          end else if (pf_hit) begin
            // Prefetch of this word is in flight: adopt it as the main read.
            pf_busy_d = 1'b0;
            cnt_d     = pf_cnt_q + 4'd1;
            state_d   = ST_WAIT;
          end else begin
            pf_busy_d  = 1'b0;
            pf_valid_d = 1'b0;
            flash_a_d  = {vga.vga_addr[22:1], 1'b0};
            en_n_d     = 1'b0;
            cnt_d      = 4'd0;
            state_d    = ST_WAIT;
          end
`else
          flash_a_d = {vga.vga_addr[22:1], 1'b0};
          en_n_d    = 1'b0;
          cnt_d     = 4'd0;
          state_d   = ST_WAIT;
`endif
        end
      end

      ST_WAIT: begin
        if (!vga.vga_re) begin
          en_n_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == RD_LAST) begin
          // Data is captured on the same edge that releases OE; flash hold time covers it.
          data_d    = flash_d;
          en_n_d    = 1'b1;
          success_d = 1'b1;
          cnt_d     = 4'd0;
          state_d   = ST_ACK;
`ifdef VGA_FLASH_PREFETCH_EN
          pf_start  = 1'b1;
          pf_base   = addr_q;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_ACK: begin
        if (!vga.vga_re || (cnt_q == ACK_LAST)) begin
          success_d = 1'b0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef VGA_FLASH_PREFETCH_EN
    // Entering ACK kicks off a read of the following word; 23-bit wrap is natural.
    if (pf_start) begin
      pf_addr_d    = pf_base + 23'd2;
      pf_addr_d[0] = 1'b0;
      flash_a_d    = pf_addr_d;
      en_n_d       = 1'b0;
      pf_busy_d    = 1'b1;
      pf_cnt_d     = 4'd0;
      pf_valid_d   = 1'b0;
    end

    // Controller dropping the request invalidates anything speculative.
    if (!vga.vga_re) begin
      pf_valid_d = 1'b0;
      pf_busy_d  = 1'b0;
      en_n_d     = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 23'd0;
      data_q     <= 16'd0;
      flash_a_q  <= 23'd0;
      en_n_q     <= 1'b1;
      success_q  <= 1'b0;
`ifdef VGA_FLASH_PREFETCH_EN
      pf_addr_q  <= 23'd0;
      pf_data_q  <= 16'd0;
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b0;
      pf_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      flash_a_q  <= flash_a_d;
      en_n_q     <= en_n_d;
      success_q  <= success_d;
`ifdef VGA_FLASH_PREFETCH_EN
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
      pf_busy_q  <= pf_busy_d;
      pf_cnt_q   <= pf_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_flash_responder.sv
// Directed bench for vga_flash_responder with a combinational NOR flash model.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Prefetch scenarios are compiled in only when VGA_FLASH_PREFETCH_EN is defined.
module tb_vga_flash_responder;

  logic        clk;
  logic        rst;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_byte_n, flash_vpen;

  int checks = 0;
  int errors = 0;

  vga_flash_responder_if vif ();

  vga_flash_responder #(.READ_CYCLES(5), .ACK_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .vga          (vif),
    .flash_a      (flash_a),
    .flash_d      (flash_d),
    .flash_ce_n   (flash_ce_n),
    .flash_oe_n   (flash_oe_n),
    .flash_we_n   (flash_we_n),
    .flash_rp_n   (flash_rp_n),
    .flash_byte_n (flash_byte_n),
    .flash_vpen   (flash_vpen)
  );

  // Flash contents: word 0 is 0xA55A, elsewhere each byte equals its low address byte.
  function automatic logic [15:0] rom_word(input logic [22:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 23'd0) return 16'hA55A;
    return {lo + 8'd1, lo};
  endfunction

  assign flash_d = rom_word(flash_a);

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Edges until vga_success next rises (after having been low); -1 if budget runs out.
  task automatic wait_rise(input int budget, output int n);
    bit seen_low;
    bit done;
    n = -1;
    done = 1'b0;
    seen_low = (vif.vga_success == 1'b0);
    for (int i = 1; i <= budget && !done; i++) begin
      step();
      if (!vif.vga_success) seen_low = 1'b1;
      else if (seen_low) begin
        n = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.vga_re = 1'b0;
    vif.vga_addr = 23'd0;
    idle_cycles(3);
    checks++; if (vif.vga_success !== 1'b0) begin errors++; $display("FAIL reset_success: got %b want 0", vif.vga_success); end
    checks++; if (vif.vga_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", vif.vga_data); end
    checks++; if (flash_a !== 23'd0) begin errors++; $display("FAIL reset_flash_a: got %h want 0", flash_a); end
    checks++; if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) begin errors++; $display("FAIL reset_ce_oe: got ce_n=%b oe_n=%b want 1/1", flash_ce_n, flash_oe_n); end
    checks++; if ({flash_we_n, flash_rp_n, flash_byte_n, flash_vpen} !== 4'b1110) begin errors++; $display("FAIL const_pins: got %b want 1110", {flash_we_n, flash_rp_n, flash_byte_n, flash_vpen}); end
    checks++; if (flash_d !== 16'hA55A) begin errors++; $display("FAIL flash_d_released: got %h want a55a", flash_d); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_single_read();
    int n;
    int h;
    vif.vga_addr = 23'd0;
    vif.vga_re = 1'b1;
    step();  // request sampled in IDLE on this edge
    checks++; if (flash_ce_n !== 1'b0 || flash_oe_n !== 1'b0) begin errors++; $display("FAIL single_ce_oe: got ce_n=%b oe_n=%b want 0/0", flash_ce_n, flash_oe_n); end
    checks++; if (flash_a !== 23'd0) begin errors++; $display("FAIL single_flash_a: got %h want 0", flash_a); end
    checks++; if (vif.vga_success !== 1'b0) begin errors++; $display("FAIL single_early_success: got %b want 0", vif.vga_success); end
    wait_rise(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: got %0d edges want 5", n); end
    checks++; if (vif.vga_data !== 16'hA55A) begin errors++; $display("FAIL single_data: got %h want a55a", vif.vga_data); end
`ifndef VGA_FLASH_PREFETCH_EN
    checks++; if (flash_ce_n !== 1'b1) begin errors++; $display("FAIL single_release: got ce_n=%b want 1", flash_ce_n); end
`endif
    h = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (vif.vga_success) h++;
      else break;
    end
    checks++; if (h !== 2) begin errors++; $display("FAIL single_ack_len: got %0d cycles want 2", h); end
    checks++; if (vif.vga_data !== 16'hA55A) begin errors++; $display("FAIL single_data_hold: got %h want a55a", vif.vga_data); end
    vif.vga_re = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_stream();
    int words;
    int low_run;
    int last_rise;
    bit prev;
    logic [7:0]  lo;
    logic [15:0] exp;
    words = 0;
    low_run = 0;
    last_rise = 0;
    prev = 1'b0;
    vif.vga_addr = 23'h10;
    vif.vga_re = 1'b1;
    for (int cyc = 1; cyc <= 200 && words < 8; cyc++) begin
      step();
      if (vif.vga_success && !prev) begin
        lo = 8'h10 + 8'(2 * words);
        exp = {lo + 8'd1, lo};
        checks++; if (vif.vga_data !== exp) begin errors++; $display("FAIL stream_word%0d: got %h want %h", words, vif.vga_data, exp); end
        if (words > 0) begin
          checks++; if (low_run < 2) begin errors++; $display("FAIL stream_gap%0d: got %0d low cycles want >=2", words, low_run); end
`ifndef VGA_FLASH_PREFETCH_EN
          checks++; if (cyc - last_rise != 9) begin errors++; $display("FAIL stream_period%0d: got %0d want 9", words, cyc - last_rise); end
`endif
        end
        last_rise = cyc;
        low_run = 0;
        words++;
        vif.vga_addr = vif.vga_addr + 23'd2;  // controller steps during ACK
      end else if (!vif.vga_success) begin
        low_run++;
      end
      prev = vif.vga_success;
    end
    vif.vga_re = 1'b0;
    checks++; if (words != 8) begin errors++; $display("FAIL stream_count: got %0d words want 8", words); end
    idle_cycles(4);
  endtask

  task automatic test_abort();
    int saw;
    int n;
    vif.vga_addr = 23'h20;
    vif.vga_re = 1'b1;
    step();  // IDLE -> WAIT
    step();
    step();  // second WAIT edge done
    checks++; if (flash_ce_n !== 1'b0) begin errors++; $display("FAIL abort_pre_ce: got %b want 0", flash_ce_n); end
    vif.vga_re = 1'b0;
    step();
    checks++; if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) begin errors++; $display("FAIL abort_release: got ce_n=%b oe_n=%b want 1/1", flash_ce_n, flash_oe_n); end
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (vif.vga_success) saw++;
      step();
    end
    checks++; if (saw != 0) begin errors++; $display("FAIL abort_no_ack: got %0d success cycles want 0", saw); end
    // A fresh request must see the full IDLE-start latency.
    vif.vga_addr = 23'h30;
    vif.vga_re = 1'b1;
    step();
    wait_rise(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL abort_followup_latency: got %0d want 5", n); end
    checks++; if (vif.vga_data !== 16'h3130) begin errors++; $display("FAIL abort_followup_data: got %h want 3130", vif.vga_data); end
    vif.vga_re = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_reset_in_ack();
    int n;
    vif.vga_addr = 23'h40;
    vif.vga_re = 1'b1;
    step();
    wait_rise(20, n);
    checks++; if (n !== 5 || vif.vga_data !== 16'h4140) begin errors++; $display("FAIL rst_ack_reach: got n=%0d data=%h want 5/4140", n, vif.vga_data); end
    rst = 1'b1;
    step();
    checks++; if (vif.vga_success !== 1'b0) begin errors++; $display("FAIL rst_ack_success: got %b want 0", vif.vga_success); end
    checks++; if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) begin errors++; $display("FAIL rst_ack_ce_oe: got ce_n=%b oe_n=%b want 1/1", flash_ce_n, flash_oe_n); end
    checks++; if (vif.vga_data !== 16'h0000 || flash_a !== 23'd0) begin errors++; $display("FAIL rst_ack_regs: got data=%h flash_a=%h want 0/0", vif.vga_data, flash_a); end
    rst = 1'b0;
    vif.vga_re = 1'b0;
    idle_cycles(4);
  endtask

`ifdef VGA_FLASH_PREFETCH_EN
  task automatic test_prefetch_wrap();
    int n;
    vif.vga_addr = 23'h7FFFFE;
    vif.vga_re = 1'b1;
    step();
    wait_rise(20, n);
    checks++; if (n !== 5 || vif.vga_data !== 16'hFFFE) begin errors++; $display("FAIL pf_wrap_first: got n=%0d data=%h want 5/fffe", n, vif.vga_data); end
    checks++; if (flash_a !== 23'd0 || flash_ce_n !== 1'b0) begin errors++; $display("FAIL pf_wrap_addr: got flash_a=%h ce_n=%b want 0/0", flash_a, flash_ce_n); end
    vif.vga_addr = 23'd0;
    wait_rise(20, n);
    // 2 ACK + GAP + IDLE sample + 1 cycle latency
    checks++; if (n !== 5) begin errors++; $display("FAIL pf_wrap_latency: got %0d want 5", n); end
    checks++; if (vif.vga_data !== 16'hA55A) begin errors++; $display("FAIL pf_wrap_data: got %h want a55a", vif.vga_data); end
    vif.vga_re = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_prefetch_miss();
    int n;
    vif.vga_addr = 23'h10;
    vif.vga_re = 1'b1;
    step();
    wait_rise(20, n);
    checks++; if (n !== 5 || vif.vga_data !== 16'h1110) begin errors++; $display("FAIL pf_miss_first: got n=%0d data=%h want 5/1110", n, vif.vga_data); end
    vif.vga_addr = 23'h100;
    wait_rise(30, n);
    // 2 ACK + GAP + IDLE sample + full 5-cycle read
    checks++; if (n !== 9) begin errors++; $display("FAIL pf_miss_latency: got %0d want 9", n); end
    checks++; if (vif.vga_data !== 16'h0100) begin errors++; $display("FAIL pf_miss_data: got %h want 0100", vif.vga_data); end
    vif.vga_re = 1'b0;
    idle_cycles(4);
  endtask
`endif

  initial begin
    rst = 1'b1;
    vif.vga_re = 1'b0;
    vif.vga_addr = 23'd0;
    test_reset();
    test_single_read();
    test_stream();
    test_abort();
    test_reset_in_ack();
`ifdef VGA_FLASH_PREFETCH_EN
    test_prefetch_wrap();
    test_prefetch_miss();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
